mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, word-address width driven to data memory.
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  CPU access request.
REQ-005 SHALL have port req_ready  output  1  unit idle, request accepted when req_valid && req_ready at a rising edge.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned  input  1  load zero-extend (1) or sign-extend (0).
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  extended load result, valid with rsp_valid.
REQ-013 SHALL have port rsp_err  output  1  access rejected, valid with rsp_valid.
REQ-014 SHALL have ports mem_en  output  1, mem_write  output  4, mem_addr  output  ADDR_W, mem_wdata  output  32, mem_rdata  input  32: data-memory port; memory has 1-cycle registered read; mem_write[i] writes byte offset i, offset 0 = bits 31:24 (big-endian).

Function
REQ-015 SHALL implement states IDLE, ISSUE, CAPTURE, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL on accept latch request; valid access -> ISSUE; rejected access -> RESP with rsp_err = 1, no mem_en.
REQ-017 SHALL in ISSUE assert mem_en = 1 for exactly one cycle from registers; mem_addr = addr[ADDR_W+1:2]; upper address bits ignored.
REQ-018 SHALL from ISSUE go to CAPTURE for loads (mem_write = 0) and to RESP for stores.
REQ-019 SHALL in CAPTURE register formatted mem_rdata into rsp_rdata, then go to RESP.
REQ-020 SHALL in RESP assert rsp_valid for one cycle, then return to IDLE; rsp_rdata holds until next load completes; rsp_err cleared on next accept.
REQ-021 SHALL give latency accept-edge to rsp_valid: load 3 cycles, store 2 cycles, rejected 1 cycle; throughput one access per 3/4 cycles.
REQ-022 SHALL form store mask: byte offset o -> bit o; half offset 0 -> 0011, offset 2 -> 1100; word -> 1111.
REQ-023 SHALL replicate store data: byte into all four lanes, half into both halves, word unchanged.
REQ-024 SHALL extract load: byte offset o -> bits [31-8o -: 8]; half offset 0 -> 31:16, offset 2 -> 15:0; extend per latched req_unsigned; word ignores req_unsigned.
REQ-025 SHALL reject req_size 11 always (rsp_err = 1).
REQ-026 SHALL ignore req_valid outside IDLE; no queuing; rsp_valid has no backpressure.

Reset
REQ-027 SHALL on rst_n low immediately force IDLE, req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mem_en = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
REQ-028 SHALL abandon any in-flight access on reset without a response; a store already issued in ISSUE is not undone.

Configuration
REQ-029 SHALL, with MEM_ALIGN_CHECK_EN defined, reject half accesses with addr[0] = 1 and word accesses with addr[1:0] != 0 (rsp_err = 1, no memory access).
REQ-030 SHALL, without MEM_ALIGN_CHECK_EN, force misaligned offsets down (half: addr[0] ignored; word: addr[1:0] ignored) and never set rsp_err except for size 11.

Structure
REQ-031 SHALL place size encodings, state enum, and mask constants in package mips32soc_mem_pkg.
REQ-032 SHALL implement load extraction/extension in combinational sub-module mem_load_align.

Verification
REQ-033 SHALL cover: word index 5 = 0x8899AABB; lb addr 0x15 -> mem_addr 5, rsp_rdata 0xFFFFFF99, rsp_valid 3 cycles after accept.
REQ-034 SHALL cover: lhu addr 0x16 -> rsp_rdata 0x0000AABB; lh addr 0x14 -> 0xFFFF8899.
REQ-035 SHALL cover: sb addr 0x17 wdata 0x12 -> mem_write 1000, mem_wdata 0x12121212; word 5 reads 0x8899AA12.
REQ-036 SHALL cover: lw addr 0x22 -> with macro rsp_err = 1, no mem_en, 1-cycle response; without macro reads word 8, rsp_err = 0.
REQ-037 SHALL cover: req_size 11 -> rsp_err = 1 in both builds; rst_n low during CAPTURE -> no rsp_valid, req_ready = 1 at once, next lw completes normally.

Source files
------------

// File: rtl/mips32soc_mem_pkg.sv
// mips32soc_mem_pkg: size encodings, FSM states, store masks and store helpers
package mips32soc_mem_pkg;

    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

    // mem_write bit i enables byte offset i; offset 0 is bits 31:24
    localparam logic [3:0] MASK_NONE    = 4'b0000;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_WORD    = 4'b1111;

    function automatic logic [3:0] store_mask(input size_e sz, input logic [1:0] off);
        return sz == SZ_BYTE ? 4'b0001 << off :
               sz == SZ_HALF ? (off[1] ? MASK_HALF_HI : MASK_HALF_LO) :
               sz == SZ_WORD ? MASK_WORD : MASK_NONE;
    endfunction

    function automatic logic [31:0] store_data(input size_e sz, input logic [31:0] wdata);
        return sz == SZ_BYTE ? {4{wdata[7:0]}} :
               sz == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/half of a big-endian word and extends it
//   rdata_i : raw memory word
//   size_i  : access size
//   off_i   : byte offset within the word (already forced aligned when needed)
//   uns_i   : 1 = zero-extend, 0 = sign-extend (ignored for words)
//   data_o  : right-justified, extended result
module mem_load_align
    import mips32soc_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  size_e       size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = off_i == 2'd0 ? rdata_i[31:24] :
            off_i == 2'd1 ? rdata_i[23:16] :
            off_i == 2'd2 ? rdata_i[15:8]  : rdata_i[7:0];
        h = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        data_o = size_i == SZ_BYTE ? {{24{~uns_i & b[7]}}, b} :
                 size_i == SZ_HALF ? {{16{~uns_i & h[15]}}, h} : rdata_i;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding CPU load/store unit in front of a 1-cycle data memory
//   req_*  : request handshake (req_ready high only when idle)
//   rsp_*  : one-cycle completion pulse with load data and error flag
//   mem_*  : data-memory port, all outputs registered
// Optional: define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses
// instead of silently aligning them down.
module mem_access_unit
    import mips32soc_mem_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [3:0]        mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q;
    size_e             size_q;
    logic              we_q, uns_q;
    logic [1:0]        off_q;
    logic              mem_en_q, rsp_valid_q, rsp_err_q;
    logic [3:0]        mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q, rsp_rdata_q, load_data;
    size_e             sz;
    logic [1:0]        off;
    logic              misal, reject, unused;

    assign unused = ^req_addr[31:ADDR_W+2];

    always_comb begin
        sz = size_e'(req_size);
`ifdef MEM_ALIGN_CHECK_EN
        off = req_addr[1:0];
        misal = (sz == SZ_HALF && req_addr[0]) || (sz == SZ_WORD && req_addr[1:0] != 2'b00);
`else
        off = sz == SZ_HALF ? {req_addr[1], 1'b0} : sz == SZ_WORD ? 2'b00 : req_addr[1:0];
        misal = 1'b0;
`endif
        reject = sz == SZ_RSVD || misal;
    end

    mem_load_align u_align (
        .rdata_i (mem_rdata),
        .size_i  (size_q),
        .off_i   (off_q),
        .uns_i   (uns_q),
        .data_o  (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            size_q      <= SZ_BYTE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            mem_en_q    <= 1'b0;
            mem_write_q <= MASK_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            mem_en_q    <= 1'b0;
            mem_write_q <= MASK_NONE;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q      <= req_we;
                    size_q    <= sz;
                    uns_q     <= req_unsigned;
                    off_q     <= off;
                    rsp_err_q <= reject;
                    if (reject) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        state_q     <= ISSUE;
                        mem_en_q    <= 1'b1;
                        mem_write_q <= req_we ? store_mask(sz, off) : MASK_NONE;
                        mem_addr_q  <= req_addr[ADDR_W+1:2];
                        mem_wdata_q <= store_data(sz, req_wdata);
                    end
                end
                ISSUE: begin
                    state_q     <= we_q ? RESP : CAPTURE;
                    rsp_valid_q <= we_q;
                end
                CAPTURE: begin
                    rsp_rdata_q <= load_data;
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = state_q == IDLE;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_en    = mem_en_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit with a big-endian memory model
module tb_mem_access_unit;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, mem_en;
    logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [3:0]  mem_write;
    logic [10:0] mem_addr;

    int checks = 0, errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        en;
        logic [10:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];

    mem_access_unit #(.ADDR_W(11)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_en(mem_en),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:2047];
    logic        mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            mem[5]     <= 32'h8899AABB;
            mem[6]     <= 32'h0;
            mem[8]     <= 32'hCAFEF00D;
            mem_loaded <= 1'b1;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int i = 0; i < 4; i++)
                if (mem_write[i]) mem[mem_addr][31-8*i -: 8] <= mem_wdata[31-8*i -: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                                input logic en, input logic [10:0] addr, input logic [3:0] mask,
                                input logic [31:0] wdata);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat; e.en = en;
        e.addr = addr; e.mask = mask; e.wdata = wdata;
        return e;
    endfunction

    task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input exp_t e);
        int n = 0, en_cnt = 0;
        logic got = 1'b0, busy_ready = 1'b0;
        logic [10:0] a = '0;
        logic [3:0] m = '0;
        logic [31:0] wd = '0;
        exp_t x;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (n < 10 && !got) begin
            @(negedge clk);
            n++;
            if (mem_en) begin en_cnt++; a = mem_addr; m = mem_write; wd = mem_wdata; end
            if (req_ready) busy_ready = 1'b1;
            if (rsp_valid) got = 1'b1;
        end
        chk({tag, " rsp_seen"}, 32'(got), 32'd1);
        x = sb.pop_front();
        chk({tag, " latency"}, 32'(n), 32'(x.lat));
        chk({tag, " err"}, 32'(rsp_err), 32'(x.err));
        chk({tag, " rdata"}, rsp_rdata, x.rdata);
        chk({tag, " mem_en_cycles"}, 32'(en_cnt), x.en ? 32'd1 : 32'd0);
        if (x.en) begin
            chk({tag, " mem_addr"}, 32'(a), 32'(x.addr));
            chk({tag, " mem_write"}, 32'(m), 32'(x.mask));
            if (we) chk({tag, " mem_wdata"}, wd, x.wdata);
        end
        chk({tag, " busy_not_ready"}, 32'(busy_ready), 32'd0);
        @(negedge clk);
        chk({tag, " pulse_end"}, 32'(rsp_valid), 32'd0);
        chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
    endtask

    logic [31:0] last;
    logic        seen;

    initial begin
        #1;
        chk("rst ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst rdata", rsp_rdata, 32'd0);
        chk("rst mem_en", 32'(mem_en), 32'd0);
        chk("rst mem_write", 32'(mem_write), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        access("lb 15",  0, 2'b00, 0, 32'h15, 0, mk(32'hFFFFFF99, 0, 3, 1, 11'd5, 4'b0000, 0));
        access("lhu 16", 0, 2'b01, 1, 32'h16, 0, mk(32'h0000AABB, 0, 3, 1, 11'd5, 4'b0000, 0));
        access("lh 14",  0, 2'b01, 0, 32'h14, 0, mk(32'hFFFF8899, 0, 3, 1, 11'd5, 4'b0000, 0));
        access("sb 17",  1, 2'b00, 0, 32'h17, 32'h12, mk(32'hFFFF8899, 0, 2, 1, 11'd5, 4'b1000, 32'h12121212));
        access("lw 14",  0, 2'b10, 0, 32'h14, 0, mk(32'h8899AA12, 0, 3, 1, 11'd5, 4'b0000, 0));
        access("lbu 14", 0, 2'b00, 1, 32'h14, 0, mk(32'h00000088, 0, 3, 1, 11'd5, 4'b0000, 0));
        access("sh 22",  1, 2'b01, 0, 32'h22, 32'h0000BEEF, mk(32'h00000088, 0, 2, 1, 11'd8, 4'b1100, 32'hBEEFBEEF));
`ifdef MEM_ALIGN_CHECK_EN
        last = 32'h00000088;
        access("lw 22",  0, 2'b10, 0, 32'h22, 0, mk(last, 1, 1, 0, 11'd0, 4'b0000, 0));
`else
        last = 32'hCAFEBEEF;
        access("lw 22",  0, 2'b10, 0, 32'h22, 0, mk(last, 0, 3, 1, 11'd8, 4'b0000, 0));
`endif
        access("size11", 0, 2'b11, 0, 32'h14, 0, mk(last, 1, 1, 0, 11'd0, 4'b0000, 0));
        access("lh 2016", 0, 2'b01, 0, 32'h2016, 0, mk(32'hFFFFAA12, 0, 3, 1, 11'd5, 4'b0000, 0));
        access("sw 18",  1, 2'b10, 0, 32'h18, 32'h01020304, mk(32'hFFFFAA12, 0, 2, 1, 11'd6, 4'b1111, 32'h01020304));
        access("lbu 1A", 0, 2'b00, 1, 32'h1A, 0, mk(32'h00000003, 0, 3, 1, 11'd6, 4'b0000, 0));

        // reset while a load sits in CAPTURE: no response, idle immediately
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst ready", 32'(req_ready), 32'd1);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst rdata", rsp_rdata, 32'd0);
        chk("midrst mem_en", 32'(mem_en), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("midrst no_rsp", 32'(seen), 32'd0);
        rst_n = 1'b1;
        access("lw 20", 0, 2'b10, 0, 32'h20, 0, mk(32'hCAFEBEEF, 0, 3, 1, 11'd8, 4'b0000, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
